inst_burst_reader: RTL and testbench

- Instruction-side line-fill engine between the instruction cache's miss port and the AXI4 read channels.
- Accepts one line-aligned physical address per miss and issues a single AXI4 INCR read burst of LINE_WORDS 32-bit beats.
- Streams each returned beat back to the cache with a valid/last strobe.
- Read-only; one outstanding burst at a time.

---
 rtl/inst_burst_reader_if.sv | 49 ++++
 rtl/inst_burst_reader.sv | 131 +++++++++++++
 tb/tb_inst_burst_reader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_burst_reader_if
//  Description : Bundles the cache-side line-fill handshake and the AXI4
//                read-address / read-data channels of the instruction-side
//                line-fill engine.
//                master : the burst reader (drives AR, rready, line_*)
//                slave  : the environment (cache + AXI slave)
//  Ports       : none (signal bundle only)
//  Revision    : 1.0  initial release
// ============================================================================
interface inst_burst_reader_if;
   // cache side
   logic [31:0] line_addr;
   logic        line_req;
   logic        line_addr_ok;
   logic [31:0] line_data;
   logic        line_valid;
   logic        line_last;
   logic        bus_err;
   // AXI4 read address channel
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   // AXI4 read data channel
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      input  line_addr, line_req, arready, rid, rdata, rresp, rlast, rvalid,
      output line_addr_ok, line_data, line_valid, line_last, bus_err,
             arid, araddr, arlen, arsize, arburst, arvalid, rready
   );

   modport slave (
      output line_addr, line_req, arready, rid, rdata, rresp, rlast, rvalid,
      input  line_addr_ok, line_data, line_valid, line_last, bus_err,
             arid, araddr, arlen, arsize, arburst, arvalid, rready
   );
endinterface
`default_nettype wire

// File: rtl/inst_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_burst_reader
//  Description : Instruction-side line-fill engine. Accepts one line-aligned
//                miss address, issues one AXI4 INCR burst of LINE_WORDS
//                32-bit beats and streams each beat back to the cache with
//                valid/last strobes. One outstanding burst at a time.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - inst_burst_reader_if.master (cache + AXI read bundle)
//  Parameters  : LINE_WORDS - beats per line (power of two, 2..16)
//                AXI_ID     - constant ARID
//                KSEG_FOLD  - 1: fold kseg0/kseg1 addresses to physical
//  Revision    : 1.0  initial release
// ============================================================================
module inst_burst_reader #(
   parameter int         LINE_WORDS = 16,
   parameter logic [3:0] AXI_ID     = 4'd0,
   parameter bit         KSEG_FOLD  = 1'b1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   inst_burst_reader_if.master   bus
);

   localparam int                 c_CNT_W = $clog2(LINE_WORDS);
   localparam int                 c_OFF   = c_CNT_W + 2;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(LINE_WORDS - 1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_ADDR = 2'd1;
   localparam logic [1:0] c_ST_DATA = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [31:0]        r_araddr;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_bus_err;

   logic [31:0]        w_line_base;
   logic [31:0]        w_fold_addr;
   logic               w_accept;
   logic               w_beat;
   logic               w_at_last;
   logic               w_unused;

   // Line offset bits are forced to zero; kseg0 (0x8..) and kseg1 (0xA..)
   // both map onto the same physical window by dropping bits 31:29.
   assign w_line_base = {bus.line_addr[31:c_OFF], {c_OFF{1'b0}}};
   assign w_fold_addr = (KSEG_FOLD && (w_line_base[31:30] == 2'b10))
                        ? {3'b000, w_line_base[28:0]} : w_line_base;

   assign w_accept  = (r_state == c_ST_IDLE) && bus.line_req;
   assign w_beat    = (r_state == c_ST_DATA) && bus.rvalid;
   assign w_at_last = (r_cnt == c_LAST);

   // rid and the in-line offset bits carry no information for this block.
   assign w_unused = ^{bus.rid, bus.line_addr[c_OFF-1:0]};

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_ST_IDLE: if (bus.line_req)          w_state_next = c_ST_ADDR;
         c_ST_ADDR: if (bus.arready)           w_state_next = c_ST_DATA;
         // The beat counter, not rlast, closes the line.
         c_ST_DATA: if (w_beat && w_at_last)   w_state_next = c_ST_IDLE;
         default:                              w_state_next = c_ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      bus.line_addr_ok = 1'b0;
      bus.arvalid      = 1'b0;
      bus.rready       = 1'b0;
      bus.line_valid   = 1'b0;
      bus.line_last    = 1'b0;
      bus.line_data    = 32'd0;
      case (r_state)
         c_ST_IDLE: bus.line_addr_ok = bus.line_req;
         c_ST_ADDR: bus.arvalid      = 1'b1;
         c_ST_DATA: begin
            bus.rready     = 1'b1;
            bus.line_valid = bus.rvalid;
            bus.line_last  = w_beat && w_at_last;
            bus.line_data  = bus.rvalid ? bus.rdata : 32'd0;
         end
         default: ;
      endcase
   end

   assign bus.arid    = AXI_ID;
   assign bus.arlen   = 8'(LINE_WORDS - 1);
   assign bus.arsize  = 3'b010;
   assign bus.arburst = 2'b01;
   assign bus.araddr  = r_araddr;
   assign bus.bus_err = r_bus_err;

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_araddr  <= 32'd0;
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_araddr <= w_fold_addr;
            r_cnt    <= '0;
         end
         if (w_beat) begin
            // Power-of-two line length lets the counter wrap on its own.
            r_cnt <= r_cnt + 1'b1;
            if ((bus.rresp != 2'b00) || (bus.rlast != w_at_last)) begin
               r_bus_err <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_burst_reader
//  Description : Self-checking bench for inst_burst_reader. A transaction-
//                level model (pending-AR flag + remaining-beat count) predicts
//                every output each cycle; directed fills pin literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_burst_reader;
   localparam int LW = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   inst_burst_reader_if bus ();

   inst_burst_reader #(.LINE_WORDS(LW), .AXI_ID(4'd0), .KSEG_FOLD(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level address rule: drop the line offset, map 0x8..-0xB.. windows
   // down to physical by subtracting the segment base.
   function automatic logic [31:0] fold_model(input logic [31:0] a);
      logic [31:0] r;
      r = a - (a % 32'(LW * 4));
      if (r >= 32'h8000_0000 && r < 32'hA000_0000)      r = r - 32'h8000_0000;
      else if (r >= 32'hA000_0000 && r < 32'hC000_0000) r = r - 32'hA000_0000;
      return r;
   endfunction

   // ------------------------------------------------------ reference model
   logic        m_have_ar;
   int          m_left;
   logic [31:0] m_araddr;
   logic        m_err;

   initial begin
      logic idle, e_ok, e_valid;
      m_have_ar = 1'b0; m_left = 0; m_araddr = 32'd0; m_err = 1'b0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         idle    = !m_have_ar && (m_left == 0);
         e_ok    = idle && bus.line_req;
         e_valid = (m_left > 0) && bus.rvalid;
         chk("line_addr_ok", bus.line_addr_ok, e_ok);
         chk("arvalid",      bus.arvalid,      m_have_ar);
         chk("araddr",       bus.araddr,       m_araddr);
         chk("rready",       bus.rready,       m_left > 0);
         chk("line_valid",   bus.line_valid,   e_valid);
         chk("line_data",    bus.line_data,    e_valid ? bus.rdata : 32'd0);
         chk("line_last",    bus.line_last,    e_valid && (m_left == 1));
         chk("bus_err",      bus.bus_err,      m_err);
         chk("ar_const",     {bus.arid, bus.arlen, bus.arsize, bus.arburst},
                             {4'd0, 8'(LW - 1), 3'b010, 2'b01});
         if (rst) begin
            m_have_ar = 1'b0; m_left = 0; m_araddr = 32'd0; m_err = 1'b0;
         end else if (e_ok) begin
            m_araddr  = fold_model(bus.line_addr);
            m_have_ar = 1'b1;
         end else if (m_have_ar && bus.arready) begin
            m_have_ar = 1'b0;
            m_left    = LW;
         end else if (e_valid) begin
            if (bus.rresp != 2'b00 || bus.rlast != (m_left == 1)) m_err = 1'b1;
            m_left--;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   int          t_nar, t_valid_n, t_last_n, t_last_at, t_data_bad;
   logic [31:0] t_araddr;

   task automatic junk_r();
      bus.rdata = $urandom;
      bus.rresp = 2'($urandom_range(0, 3));
      bus.rlast = 1'($urandom_range(0, 1));
      bus.rid   = 4'($urandom_range(0, 15));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         bus.line_req = 1'b0;
         bus.arready  = 1'($urandom_range(0, 1));
         bus.rvalid   = 1'($urandom_range(0, 1));
         junk_r();
         @(posedge clk); #1;
      end
      bus.rvalid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Caller is just past a rising edge with the DUT idle.
   // gap_mode: 0 back-to-back, 1 pattern 1,0,0,..., 2 random.
   task automatic fill(input logic [31:0] addr, input int ar_wait, input int gap_mode,
                       input int bad_resp, input int bad_last, input int abort_beat,
                       input bit keep_req, input bit seq_data);
      int  c, k;
      bit  hs, v;
      t_nar = 0; t_valid_n = 0; t_last_n = 0; t_last_at = -1; t_data_bad = 0;
      t_araddr = 32'hxxxx_xxxx;
      bus.line_req  = 1'b1;
      bus.line_addr = addr;
      bus.arready   = 1'b0;
      bus.rvalid    = 1'($urandom_range(0, 1));
      junk_r();
      @(negedge clk);
      chk("accept_ok", bus.line_addr_ok, 1'b1);
      @(posedge clk); #1;
      // address phase: requests while busy must be ignored
      hs = 1'b0; c = 0;
      while (!hs && c < 100) begin
         if (!keep_req) begin
            bus.line_req  = 1'($urandom_range(0, 1));
            bus.line_addr = $urandom;
         end
         bus.arready = (c >= ar_wait);
         bus.rvalid  = 1'($urandom_range(0, 1));
         junk_r();
         @(negedge clk);
         if (bus.arvalid) begin t_nar++; t_araddr = bus.araddr; end
         hs = bus.arvalid && bus.arready;
         @(posedge clk); #1;
         c++;
      end
      if (!hs) chk("ar_timeout", 32'd0, 32'd1);
      bus.arready = 1'b0;
      // data phase
      k = 0; c = 0;
      while (k < LW && c < 400) begin
         if (k == abort_beat) begin
            rst = 1'b1; bus.line_req = 1'b0; bus.rvalid = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_arvalid",    bus.arvalid,    1'b0);
            chk("rst_rready",     bus.rready,     1'b0);
            chk("rst_line_valid", bus.line_valid, 1'b0);
            chk("rst_bus_err",    bus.bus_err,    1'b0);
            @(posedge clk); #1;
            bus.rvalid = 1'b0;
            return;
         end
         if (!keep_req) begin
            bus.line_req  = 1'($urandom_range(0, 1));
            bus.line_addr = $urandom;
         end
         v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (c % 3 == 0)
                             : 1'($urandom_range(0, 1));
         junk_r();
         bus.rvalid = v;
         if (v) begin
            bus.rdata = seq_data ? 32'(k) : $urandom;
            bus.rresp = (k == bad_resp) ? 2'b10 : 2'b00;
            bus.rlast = (k == LW - 1) ^ (k == bad_last);
         end
         @(negedge clk);
         if (bus.line_valid) begin
            t_valid_n++;
            if (seq_data && bus.line_data != 32'(k)) t_data_bad++;
            if (bus.line_last) begin t_last_n++; t_last_at = k; end
         end
         if (bus.rvalid && bus.rready) k++;
         @(posedge clk); #1;
         c++;
      end
      if (k < LW) chk("data_timeout", 32'(k), 32'(LW));
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      if (!keep_req) bus.line_req = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b1;
      bus.line_req = 1'b0; bus.line_addr = 32'd0; bus.arready = 1'b0;
      bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rlast = 1'b0;
      bus.rid = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("reset_arvalid", bus.arvalid, 1'b0);
      chk("reset_rready",  bus.rready,  1'b0);
      chk("reset_valid",   bus.line_valid, 1'b0);
      chk("reset_bus_err", bus.bus_err, 1'b0);
      chk("reset_araddr",  bus.araddr,  32'd0);
      @(posedge clk); #1;

      // basic fill
      fill(32'h0000_1040, 0, 0, -1, -1, -1, 1'b0, 1'b1);
      chk("basic_araddr", t_araddr, 32'h0000_1040);
      chk("basic_nar",    t_nar, 1);
      chk("basic_beats",  t_valid_n, LW);
      chk("basic_lastn",  t_last_n, 1);
      chk("basic_lastat", t_last_at, LW - 1);
      chk("basic_data",   t_data_bad, 0);
      @(negedge clk);
      chk("basic_idle_rready", bus.rready, 1'b0);
      chk("basic_bus_err",     bus.bus_err, 1'b0);
      @(posedge clk); #1;

      // fold + AR back-pressure
      fill(32'hBFC0_0004, 5, 0, -1, -1, -1, 1'b0, 1'b0);
      chk("fold_bfc_araddr", t_araddr, 32'h1FC0_0000);
      chk("fold_bfc_nar",    t_nar, 6);
      fill(32'h9FC0_0040, 0, 2, -1, -1, -1, 1'b0, 1'b0);
      chk("fold_9fc_araddr", t_araddr, 32'h1FC0_0040);
      fill(32'h0000_1000, 1, 2, -1, -1, -1, 1'b0, 1'b0);
      chk("fold_low_araddr", t_araddr, 32'h0000_1000);
      fill(32'hC000_0000, 2, 2, -1, -1, -1, 1'b0, 1'b0);
      chk("fold_c00_araddr", t_araddr, 32'hC000_0000);

      // gapped data
      fill(32'h0000_2000, 1, 1, -1, -1, -1, 1'b0, 1'b1);
      chk("gap_beats",  t_valid_n, LW);
      chk("gap_lastat", t_last_at, LW - 1);
      chk("gap_data",   t_data_bad, 0);

      // SLVERR on beat 3, sticky across a clean fill
      fill(32'h0000_3000, 0, 0, 3, -1, -1, 1'b0, 1'b1);
      chk("resp_err_beats", t_valid_n, LW);
      chk("resp_err_set",   bus.bus_err, 1'b1);
      fill(32'h0000_3040, 0, 2, -1, -1, -1, 1'b0, 1'b0);
      chk("resp_err_sticky", bus.bus_err, 1'b1);
      do_reset();
      chk("resp_err_cleared", bus.bus_err, 1'b0);

      // early rlast on beat 7
      fill(32'h0000_4000, 0, 2, -1, 7, -1, 1'b0, 1'b1);
      chk("early_last_set",   bus.bus_err, 1'b1);
      chk("early_last_beats", t_valid_n, LW);
      do_reset();

      // back-to-back with line_req held high
      fill(32'h0000_5000, 1, 0, -1, -1, -1, 1'b1, 1'b1);
      fill(32'h0000_6080, 0, 2, -1, -1, -1, 1'b1, 1'b0);
      chk("b2b_second_araddr", t_araddr, 32'h0000_6080);
      bus.line_req = 1'b0;
      @(posedge clk); #1;

      // reset after beat 5 (error earlier so the clear is visible)
      fill(32'h0000_7000, 0, 0, 2, -1, 6, 1'b0, 1'b1);
      fill(32'h0000_7100, 0, 0, -1, -1, -1, 1'b0, 1'b1);
      chk("post_rst_beats",  t_valid_n, LW);
      chk("post_rst_araddr", t_araddr, 32'h0000_7100);

      // randomized fills
      for (int i = 0; i < 30; i++) begin
         fill($urandom, $urandom_range(0, 4), 2,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, LW - 1) : -1,
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, LW - 1) : -1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, LW - 1) : -1,
              1'b0, 1'b0);
         idle_cycles($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) do_reset();
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
